// File: rtl/gactx_pkg.sv
// Shared definitions for the GACT-X traceback packer: direction codes, FSM states and
// trailer field placement.
package gactx_pkg;

  typedef enum logic [1:0] {
    DirZero = 2'd0,
    DirV    = 2'd1,
    DirH    = 2'd2,
    DirM    = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    StIdle,
    StPack,
    StFlush,
    StTrailer,
    StDrain
  } pack_state_e;

  // Trailer layout from the LSB: H offset, V offset, step count, zero padding.
  localparam int unsigned TrlHLsb = 0;

  function automatic int unsigned trl_v_lsb(int unsigned ref_len_width);
    return ref_len_width;
  endfunction

  function automatic int unsigned trl_steps_lsb(int unsigned ref_len_width);
    return 2 * ref_len_width;
  endfunction

endpackage

// File: rtl/gactx_tb_fifo.sv
// Synchronous first-word-fall-through FIFO; a read in the same cycle as a write into a
// full FIFO frees the slot so the write is still accepted.
module gactx_tb_fifo #(
  parameter int unsigned WIDTH     = 65,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned Depth = 2 ** LOG_DEPTH;

  logic [WIDTH-1:0]     mem_q [Depth];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   cnt_q;
  logic                 wr_ok, rd_ok;

  assign full    = (cnt_q == (LOG_DEPTH + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/gactx_tb_packer.sv
// Packs 2-bit traceback directions LSB-first into output words, then appends a trailer word
// with the alignment totals; words stream out through a small FWFT FIFO.
module gactx_tb_packer
  import gactx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned REF_LEN_WIDTH  = 12,
  parameter int unsigned LOG_NUM_PE     = 6,
  parameter int unsigned OUT_WIDTH      = 64,
  parameter int unsigned LOG_FIFO_DEPTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       in_dir,
  input  logic                             in_dir_valid,
  input  logic                             in_done,
  input  logic [ADDR_WIDTH+LOG_NUM_PE-1:0] in_num_tb_steps,
  input  logic [REF_LEN_WIDTH-1:0]         in_H_offset,
  input  logic [REF_LEN_WIDTH-1:0]         in_V_offset,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow
);

  localparam int unsigned StepsW   = ADDR_WIDTH + LOG_NUM_PE;
  localparam int unsigned DirsPerW = OUT_WIDTH / 2;
  localparam int unsigned CntW     = $clog2(DirsPerW);
  localparam int unsigned VLsb     = trl_v_lsb(REF_LEN_WIDTH);
  localparam int unsigned StepsLsb = trl_steps_lsb(REF_LEN_WIDTH);

  pack_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic                 ovf_q, ovf_d;
  logic [StepsW-1:0]    steps_q, steps_d;
  logic [REF_LEN_WIDTH-1:0] h_q, h_d, v_q, v_d;

  logic                 fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [OUT_WIDTH:0]   fifo_wdata, fifo_rdata;
  logic                 wr_room;
  dir_e                 dir;
  logic [OUT_WIDTH-1:0] dir_ext, packed_word, trailer;

  assign dir         = dir_e'(in_dir);
  assign dir_ext     = {{(OUT_WIDTH - 2){1'b0}}, dir};
  assign packed_word = word_q | (dir_ext << {cnt_q, 1'b0});
  assign fifo_rd     = out_valid && out_ready;
  // A pop in the same cycle makes room even when the FIFO currently reports full.
  assign wr_room     = !fifo_full || fifo_rd;

  always_comb begin
    trailer                              = '0;
    trailer[TrlHLsb +: REF_LEN_WIDTH]    = h_q;
    trailer[VLsb +: REF_LEN_WIDTH]       = v_q;
    trailer[StepsLsb +: StepsW]          = steps_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    ovf_d      = ovf_q;
    steps_d    = steps_q;
    h_d        = h_q;
    v_d        = v_q;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPack;
          cnt_d   = '0;
          word_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      StPack: begin
        if (in_dir_valid) begin
          if (cnt_q == CntW'(DirsPerW - 1)) begin
            // Upstream cannot be stalled, so a full word with no room is dropped.
            fifo_wr    = wr_room;
            fifo_wdata = {1'b0, packed_word};
            if (!wr_room) ovf_d = 1'b1;
            cnt_d  = '0;
            word_d = '0;
          end else begin
            cnt_d  = cnt_q + CntW'(1);
            word_d = packed_word;
          end
        end
        if (in_done) begin
          steps_d = in_num_tb_steps;
          h_d     = in_H_offset;
          v_d     = in_V_offset;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StTrailer;
        end else if (wr_room) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {1'b0, word_q};
          cnt_d      = '0;
          word_d     = '0;
          state_d    = StTrailer;
        end
      end
      StTrailer: begin
        if (wr_room) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {1'b1, trailer};
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      steps_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      steps_q <= steps_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  gactx_tb_fifo #(
    .WIDTH    (OUT_WIDTH + 1),
    .LOG_DEPTH(LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fifo_wr),
    .wr_data(fifo_wdata),
    .full   (fifo_full),
    .rd_en  (fifo_rd),
    .rd_data(fifo_rdata),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[OUT_WIDTH-1:0];
  assign out_last  = fifo_rdata[OUT_WIDTH] && !fifo_empty;
  assign busy      = (state_q != StIdle);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_gactx_tb_packer.sv
// Bench for gactx_tb_packer: directed cases plus random alignments compared against a
// list-level model of the packed output stream.
module tb_gactx_tb_packer;

  localparam int unsigned AW = 20;
  localparam int unsigned RW = 12;
  localparam int unsigned LP = 6;
  localparam int unsigned OW = 64;
  localparam int unsigned SW = AW + LP;

  logic          clk, rst, start, in_dir_valid, in_done, out_ready;
  logic [1:0]    in_dir;
  logic [SW-1:0] in_num_tb_steps;
  logic [RW-1:0] in_H_offset, in_V_offset;
  logic [OW-1:0] out_data;
  logic          out_valid, out_last, busy, overflow;

  gactx_tb_packer #(
    .ADDR_WIDTH    (AW),
    .REF_LEN_WIDTH (RW),
    .LOG_NUM_PE    (LP),
    .OUT_WIDTH     (OW),
    .LOG_FIFO_DEPTH(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_dir         (in_dir),
    .in_dir_valid   (in_dir_valid),
    .in_done        (in_done),
    .in_num_tb_steps(in_num_tb_steps),
    .in_H_offset    (in_H_offset),
    .in_V_offset    (in_V_offset),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  bit          rand_ready = 1'b0;
  logic [1:0]  dir_q[$];
  logic [63:0] exp_d[$], got_d[$];
  logic        exp_l[$], got_l[$];

  // Output monitor: a word is consumed when valid and ready are both high at the edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: dirs packed 32 per word LSB-first, partial word zero-padded, then trailer.
  task automatic build_expected(input logic [SW-1:0] steps, input logic [RW-1:0] h,
                                input logic [RW-1:0] v);
    logic [63:0] w;
    w = '0;
    exp_d.delete();
    exp_l.delete();
    for (int i = 0; i < dir_q.size(); i++) begin
      w[2 * (i % 32) +: 2] = dir_q[i];
      if (i % 32 == 31) begin
        exp_d.push_back(w);
        exp_l.push_back(1'b0);
        w = '0;
      end
    end
    if (dir_q.size() % 32 != 0) begin
      exp_d.push_back(w);
      exp_l.push_back(1'b0);
    end
    exp_d.push_back(64'(h) | (64'(v) << 12) | (64'(steps) << 24));
    exp_l.push_back(1'b1);
  endtask

  task automatic feed_dirs(input bit gaps, input bit merge, input bit send_done,
                           input logic [SW-1:0] steps, input logic [RW-1:0] h,
                           input logic [RW-1:0] v);
    for (int i = 0; i < dir_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) cyc();
      in_dir_valid = 1'b1;
      in_dir       = dir_q[i];
      if (send_done && merge && i == dir_q.size() - 1) begin
        in_done = 1'b1;
        in_num_tb_steps = steps;
        in_H_offset = h;
        in_V_offset = v;
      end
      cyc();
      in_dir_valid = 1'b0;
      in_done      = 1'b0;
    end
    if (send_done && (!merge || dir_q.size() == 0)) begin
      in_done = 1'b1;
      in_num_tb_steps = steps;
      in_H_offset = h;
      in_V_offset = v;
      cyc();
      in_done = 1'b0;
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq({tag, ".busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      cyc();
      n++;
    end
    check_eq({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_out(input string tag);
    int n;
    check_eq({tag, ".nwords"}, 64'(got_d.size()), 64'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s.data%0d", tag, i), got_d[i], exp_d[i]);
      check_eq($sformatf("%s.last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
    got_d.delete();
    got_l.delete();
  endtask

  task automatic run_align(input string tag, input bit gaps, input bit merge,
                           input logic [SW-1:0] steps, input logic [RW-1:0] h,
                           input logic [RW-1:0] v);
    build_expected(steps, h, v);
    do_start(tag);
    feed_dirs(gaps, merge, 1'b1, steps, h, v);
    wait_idle(tag);
    compare_out(tag);
    check_eq({tag, ".ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_dir = '0; in_dir_valid = 1'b0; in_done = 1'b0;
    in_num_tb_steps = '0; in_H_offset = '0; in_V_offset = '0; out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.last", 64'(out_last), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.ovf", 64'(overflow), 64'd0);

    // 1: five dirs then done
    dir_q = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd3};
    run_align("t1", 1'b0, 1'b0, 26'd5, 12'd1, 12'd2);

    // 2: exactly one full word; dirs offered while idle must be ignored
    in_dir_valid = 1'b1; in_dir = 2'd1;
    cyc(); cyc(); cyc();
    in_dir_valid = 1'b0;
    dir_q.delete();
    for (int i = 0; i < 32; i++) dir_q.push_back(2'd3);
    run_align("t2", 1'b0, 1'b0, 26'd32, 12'd3, 12'd4);

    // 3: no dirs, trailer only
    dir_q.delete();
    run_align("t3", 1'b0, 1'b0, 26'd0, 12'd0, 12'd0);

    // 4: nine full words into an eight-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    dir_q.delete();
    for (int i = 0; i < 256; i++) dir_q.push_back(2'($urandom));
    build_expected(26'd288, 12'd5, 12'd6);
    do_start("t4");
    feed_dirs(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("t4.ovf8", 64'(overflow), 64'd0);
    dir_q.delete();
    for (int i = 0; i < 32; i++) dir_q.push_back(2'($urandom));
    feed_dirs(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("t4.ovf9", 64'(overflow), 64'd1);
    dir_q.delete();
    feed_dirs(1'b0, 1'b0, 1'b1, 26'd288, 12'd5, 12'd6);
    cyc(); cyc();
    check_eq("t4.stall", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle("t4");
    compare_out("t4");
    check_eq("t4.ovfhold", 64'(overflow), 64'd1);

    // 5: dir together with done lands in the partial word
    dir_q = '{2'd2, 2'd1, 2'd3};
    run_align("t5", 1'b0, 1'b1, 26'd12, 12'd7, 12'd9);
    n = exp_d.size();
    check_eq("t5.trlconst", exp_d[n - 1], 64'h0000_0000_0C00_9007);

    // 6: reset with three words buffered
    out_ready = 1'b0;
    dir_q.delete();
    for (int i = 0; i < 96; i++) dir_q.push_back(2'($urandom));
    do_start("t6");
    check_eq("t6.ovfclr", 64'(overflow), 64'd0);
    feed_dirs(1'b0, 1'b0, 1'b0, '0, '0, '0);
    cyc();
    check_eq("t6.pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    check_eq("t6.valid", 64'(out_valid), 64'd0);
    check_eq("t6.ovf", 64'(overflow), 64'd0);
    check_eq("t6.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    got_d.delete();
    got_l.delete();
    dir_q = '{2'd1, 2'd2};
    run_align("t6b", 1'b0, 1'b0, 26'd2, 12'd8, 12'd9);

    // random alignments, at most seven data words so the FIFO cannot overflow
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 224);
      dir_q.delete();
      for (int i = 0; i < n; i++) dir_q.push_back(2'($urandom));
      run_align($sformatf("rnd%0d", k), 1'b1, bit'($urandom_range(0, 1)),
                SW'($urandom), RW'($urandom), RW'($urandom));
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
